// File: rtl/sign_ext_arbiter_pkg.sv
// rtl/sign_ext_arbiter_pkg.sv - shared widths, length encodings and FSM states for sign_ext_arbiter
package sign_ext_arbiter_pkg;

    localparam int DATA_W = 26;
    localparam int OUT_W  = 32;

    localparam logic LEN_16 = 1'b0;
    localparam logic LEN_26 = 1'b1;

    // EMPTY: output register holds nothing; FULL: rsp_data/rsp_id are valid
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/sign_ext_arbiter_if.sv
// rtl/sign_ext_arbiter_if.sv - request/response bundle between requesters, consumer and sign_ext_arbiter
// Ports: two requests (valid/ready/data/len/zext), one response (valid/ready/data/id),
// and the two saturating grant counters. slave = arbiter side, master = requester/consumer side.
interface sign_ext_arbiter_if #(
    parameter int CNT_W = 16
);
    import sign_ext_arbiter_pkg::*;

    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_data;
    logic              req0_len;
    logic              req0_zext;

    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_data;
    logic              req1_len;
    logic              req1_zext;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [OUT_W-1:0]  rsp_data;
    logic              rsp_id;

    logic [CNT_W-1:0]  grant_cnt0;
    logic [CNT_W-1:0]  grant_cnt1;

    modport slave (
        input  req0_valid, req0_data, req0_len, req0_zext,
        input  req1_valid, req1_data, req1_len, req1_zext,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_data, rsp_id,
        output grant_cnt0, grant_cnt1
    );

    modport master (
        output req0_valid, req0_data, req0_len, req0_zext,
        output req1_valid, req1_data, req1_len, req1_zext,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_data, rsp_id,
        input  grant_cnt0, grant_cnt1
    );

endinterface

// File: rtl/sign_ext_arbiter_ext_datapath.sv
// rtl/sign_ext_arbiter_ext_datapath.sv - combinational 16/26-bit sign/zero extension to 32 bits
// Ports: i_data (26b field, right-aligned), i_len (LEN_16/LEN_26), i_zext (1 = zero-extend),
// o_result (32b extended value).
module ext_datapath
    import sign_ext_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_len,
    input  logic              i_zext,
    output logic [OUT_W-1:0]  o_result
);

    logic w_fill;

    always_comb begin
        w_fill   = 1'b0;
        o_result = '0;
        if (i_len == LEN_26) begin
            w_fill   = i_data[25] & ~i_zext;
            o_result = {{(OUT_W-26){w_fill}}, i_data[25:0]};
        end else begin
            // bits 25:16 are dropped here, never forwarded
            w_fill   = i_data[15] & ~i_zext;
            o_result = {{(OUT_W-16){w_fill}}, i_data[15:0]};
        end
    end

endmodule

// File: rtl/sign_ext_arbiter.sv
// rtl/sign_ext_arbiter.sv - round-robin arbiter sharing one extension datapath, single-entry output stage
// Ports: clk, rst_n (async active-low), bus (sign_ext_arbiter_if.slave: both requests,
// the response stage and the grant counters).
module sign_ext_arbiter
    import sign_ext_arbiter_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    sign_ext_arbiter_if.slave   bus
);

    state_t            r_state;
    state_t            w_next_state;
    logic              r_prio;
    logic [OUT_W-1:0]  r_data;
    logic              r_id;
    logic [CNT_W-1:0]  r_cnt0;
    logic [CNT_W-1:0]  r_cnt1;

    logic              w_free;
    logic              w_grant0;
    logic              w_grant1;
    logic              w_ready0;
    logic              w_ready1;
    logic              w_accept;
    logic              w_drain;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_sel_len;
    logic              w_sel_zext;
    logic [OUT_W-1:0]  w_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_free       = (r_state == EMPTY) || bus.rsp_ready;
        w_drain      = (r_state == FULL) && bus.rsp_ready;
        w_grant0     = bus.req0_valid && (!bus.req1_valid || !r_prio);
        w_grant1     = bus.req1_valid && (!bus.req0_valid ||  r_prio);
        // rst_n gating keeps both readys low while reset is held
        w_ready0     = rst_n && w_grant0 && w_free;
        w_ready1     = rst_n && w_grant1 && w_free;
        w_accept     = w_ready0 || w_ready1;
        w_sel_data   = w_grant1 ? bus.req1_data : bus.req0_data;
        w_sel_len    = w_grant1 ? bus.req1_len  : bus.req0_len;
        w_sel_zext   = w_grant1 ? bus.req1_zext : bus.req0_zext;
        w_next_state = r_state;
        case (r_state)
            EMPTY:   if (w_accept)             w_next_state = FULL;
            FULL:    if (w_drain && !w_accept) w_next_state = EMPTY;
            default:                           w_next_state = EMPTY;
        endcase
    end

    ext_datapath u_ext (
        .i_data   (w_sel_data),
        .i_len    (w_sel_len),
        .i_zext   (w_sel_zext),
        .o_result (w_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio <= 1'b0;
            r_data <= '0;
            r_id   <= 1'b0;
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (w_accept) begin
            r_data <= w_ext;
            r_id   <= w_ready1;
            // loser gets priority next time both request
            r_prio <= ~w_ready1;
            if (w_ready0 && (r_cnt0 != '1)) r_cnt0 <= r_cnt0 + 1'b1;
            if (w_ready1 && (r_cnt1 != '1)) r_cnt1 <= r_cnt1 + 1'b1;
        end
    end

    assign bus.req0_ready = w_ready0;
    assign bus.req1_ready = w_ready1;
    assign bus.rsp_valid  = (r_state == FULL);
    assign bus.rsp_data   = r_data;
    assign bus.rsp_id     = r_id;
    assign bus.grant_cnt0 = r_cnt0;
    assign bus.grant_cnt1 = r_cnt1;

endmodule

// File: tb/tb_sign_ext_arbiter.sv
// tb/tb_sign_ext_arbiter.sv - self-checking bench for sign_ext_arbiter against a behavioural model
module tb_sign_ext_arbiter;

    logic clk;
    logic rst_n;

    int total = 0;
    int bad   = 0;

    sign_ext_arbiter_if #(.CNT_W(16)) bus   ();
    sign_ext_arbiter_if #(.CNT_W(2))  bus_s ();

    sign_ext_arbiter #(.CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    sign_ext_arbiter #(.CNT_W(2)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural model state
    int          m_valid;
    longint      m_data;
    int          m_id;
    int          m_pref;
    int          m_cnt0;
    int          m_cnt1;
    logic [31:0] held;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic longint ref_ext(input longint d, input int len, input int zext);
        longint n;
        longint v;
        n = (len != 0) ? 26 : 16;
        v = d % (longint'(1) << n);
        if (zext == 0 && v >= (longint'(1) << (n - 1)))
            v = v - (longint'(1) << n) + (longint'(1) << 32);
        return v;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_data = 0; m_id = 0; m_pref = 0; m_cnt0 = 0; m_cnt1 = 0;
    endtask

    task automatic drive(input bit v0, input logic [25:0] d0, input bit l0, input bit z0,
                         input bit v1, input logic [25:0] d1, input bit l1, input bit z1,
                         input bit rr);
        bus.req0_valid = v0; bus.req0_data = d0; bus.req0_len = l0; bus.req0_zext = z0;
        bus.req1_valid = v1; bus.req1_data = d1; bus.req1_len = l1; bus.req1_zext = z1;
        bus.rsp_ready  = rr;
    endtask

    // one clock: check readys from the model, clock, update model, check outputs
    task automatic step();
        int     can_take;
        int     win;
        longint nd;
        #1;
        can_take = (m_valid == 0) || (bus.rsp_ready == 1'b1);
        win = -1;
        if (can_take) begin
            if (bus.req0_valid && bus.req1_valid) win = m_pref;
            else if (bus.req0_valid)              win = 0;
            else if (bus.req1_valid)              win = 1;
        end
        check_val("req0_ready", 64'(bus.req0_ready), 64'(win == 0));
        check_val("req1_ready", 64'(bus.req1_ready), 64'(win == 1));
        if (win == 0) nd = ref_ext(longint'(bus.req0_data), int'(bus.req0_len), int'(bus.req0_zext));
        else          nd = ref_ext(longint'(bus.req1_data), int'(bus.req1_len), int'(bus.req1_zext));
        @(posedge clk);
        if (win >= 0) begin
            m_valid = 1;
            m_data  = nd;
            m_id    = win;
            m_pref  = 1 - win;
            if (win == 0) m_cnt0 = (m_cnt0 < 65535) ? m_cnt0 + 1 : m_cnt0;
            else          m_cnt1 = (m_cnt1 < 65535) ? m_cnt1 + 1 : m_cnt1;
        end else if (m_valid == 1 && bus.rsp_ready) begin
            m_valid = 0;
        end
        @(negedge clk);
        check_val("rsp_valid",  64'(bus.rsp_valid),  64'(m_valid));
        check_val("rsp_data",   64'(bus.rsp_data),   64'(m_data));
        check_val("rsp_id",     64'(bus.rsp_id),     64'(m_id));
        check_val("grant_cnt0", 64'(bus.grant_cnt0), 64'(m_cnt0));
        check_val("grant_cnt1", 64'(bus.grant_cnt1), 64'(m_cnt1));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_val("rst_rsp_valid", 64'(bus.rsp_valid),  64'd0);
        check_val("rst_rsp_data",  64'(bus.rsp_data),   64'd0);
        check_val("rst_rsp_id",    64'(bus.rsp_id),     64'd0);
        check_val("rst_ready0",    64'(bus.req0_ready), 64'd0);
        check_val("rst_ready1",    64'(bus.req1_ready), 64'd0);
        check_val("rst_cnt0",      64'(bus.grant_cnt0), 64'd0);
        check_val("rst_cnt1",      64'(bus.grant_cnt1), 64'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, '0, 0, 0, 0, '0, 0, 0, 1);
        bus_s.req0_valid = 0; bus_s.req0_data = '0; bus_s.req0_len = 0; bus_s.req0_zext = 0;
        bus_s.req1_valid = 0; bus_s.req1_data = '0; bus_s.req1_len = 0; bus_s.req1_zext = 0;
        bus_s.rsp_ready  = 1;
        model_reset();
        @(negedge clk);
        do_reset();

        // directed extension cases
        drive(1, 26'h000FF0F, 0, 0, 0, '0, 0, 0, 1); step();
        check_val("tp_sext16", 64'(bus.rsp_data), 64'h0FFFFFF0F);
        check_val("tp_id0",    64'(bus.rsp_id),   64'd0);
        check_val("tp_cnt0",   64'(bus.grant_cnt0), 64'd1);
        drive(0, '0, 0, 0, 1, 26'h2000000, 1, 0, 1); step();
        check_val("tp_sext26", 64'(bus.rsp_data), 64'h0FE000000);
        check_val("tp_id1",    64'(bus.rsp_id),   64'd1);
        drive(0, '0, 0, 0, 1, 26'h2000000, 1, 1, 1); step();
        check_val("tp_zext26", 64'(bus.rsp_data), 64'h002000000);
        drive(1, 26'h0008000, 0, 1, 0, '0, 0, 0, 1); step();
        check_val("tp_zext16", 64'(bus.rsp_data), 64'h000008000);
        drive(1, 26'h3FF0F0F, 0, 0, 0, '0, 0, 0, 1); step();
        check_val("tp_upper_ignored", 64'(bus.rsp_data), 64'h000000F0F);
        drive(0, '0, 0, 0, 0, '0, 0, 0, 1); step();
        check_val("tp_drained", 64'(bus.rsp_valid), 64'd0);

        // continuous dual requests alternate from prio 0
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1, 26'(i * 3), 0, 0, 1, 26'(i * 5 + 1), 1, 1, 1);
            step();
            check_val("alt_id", 64'(bus.rsp_id), 64'(i % 2));
        end
        check_val("alt_cnt0", 64'(bus.grant_cnt0), 64'd3);
        check_val("alt_cnt1", 64'(bus.grant_cnt1), 64'd3);

        // backpressure
        drive(1, 26'h0001234, 0, 0, 0, '0, 0, 0, 1); step();
        held = bus.rsp_data;
        check_val("bp_loaded", 64'(held), 64'h000001234);
        for (int i = 0; i < 4; i++) begin
            drive(1, 26'(i + 7), 0, 0, 1, 26'(i + 9), 1, 0, 0);
            step();
            check_val("bp_stable_data", 64'(bus.rsp_data), 64'(held));
            check_val("bp_stable_id",   64'(bus.rsp_id),   64'd0);
        end
        drive(1, 26'h0000077, 0, 0, 1, 26'h0000099, 1, 0, 1); step();
        check_val("bp_thru_valid", 64'(bus.rsp_valid), 64'd1);
        check_val("bp_thru_id",    64'(bus.rsp_id),    64'd1);
        check_val("bp_thru_data",  64'(bus.rsp_data),  64'h000000099);

        // reset while a result is held and both request
        drive(1, 26'h0000011, 0, 0, 1, 26'h0000022, 0, 0, 0);
        check_val("pre_rst_valid", 64'(bus.rsp_valid), 64'd1);
        do_reset();
        drive(1, 26'h0000011, 0, 0, 1, 26'h0000022, 0, 0, 1); step();
        check_val("post_rst_id", 64'(bus.rsp_id), 64'd0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 26'($urandom()), 1'($urandom()), 1'($urandom()),
                  $urandom_range(0, 3) != 0, 26'($urandom()), 1'($urandom()), 1'($urandom()),
                  $urandom_range(0, 2) != 0);
            step();
        end

        // counter saturation on the CNT_W=2 instance
        bus_s.req0_valid = 1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 2) check_val("sat_cnt0_at3", 64'(bus_s.grant_cnt0), 64'd3);
        end
        bus_s.req0_valid = 0;
        check_val("sat_cnt0", 64'(bus_s.grant_cnt0), 64'd3);
        check_val("sat_cnt1", 64'(bus_s.grant_cnt1), 64'd0);
        check_val("sat_valid", 64'(bus_s.rsp_valid), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sign_ext_arbiter.md
# sign_ext_arbiter

Shares one 32-bit sign/zero-extension datapath between two requesters: the decode stage (16-bit immediates) and the jump/branch target unit (26-bit fields). Each requester presents a field with a width and mode select over a valid/ready handshake. The arbiter grants one per cycle, round-robin, and registers the extended result with a requester ID into a single-entry output stage with its own valid/ready handshake. It also keeps per-requester saturating grant counters for performance monitoring.

## Interface
- `CNT_W`, 16, width of each grant counter

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `req0_valid`, `req1_valid`  in  1  request present
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle when high with valid
- `req0_data`, `req1_data`  in  26  field, right-aligned; bits above the selected width ignored
- `req0_len`, `req1_len`  in  1  0 = 16-bit field, 1 = 26-bit field
- `req0_zext`, `req1_zext`  in  1  1 = zero-extend, 0 = sign-extend
- `rsp_valid`  out  1  result held in output register
- `rsp_ready`  in  1  consumer takes result
- `rsp_data`  out  32  extended result
- `rsp_id`  out  1  requester that produced `rsp_data`
- `grant_cnt0`, `grant_cnt1`  out  CNT_W  accepted-request counts, saturating

## Operation
- Extension: N = 16 or 26 per `len`. Sign mode: `rsp_data` = {(32-N) copies of data[N-1], data[N-1:0]}. Zero mode: upper 32-N bits are 0.
- Output stage free = !rsp_valid || rsp_ready.
- Grant, combinational: if only one valid, grant it. If both valid, grant the side named by priority pointer `prio` (0 or 1). `reqX_ready` = grant_X && stage free. At most one ready high per cycle.
- On accept (valid && ready): load `rsp_data`, `rsp_id`, and set rsp_valid. Set `prio` to the non-granted side. Increment that requester's counter, which holds at all-ones.
- On rsp_valid && rsp_ready with no accept: clear rsp_valid.
- Drain and accept in the same cycle: the new result replaces the old one, rsp_valid stays 1, throughput 1/cycle.
- FSM, 2 states:
  - EMPTY → FULL on accept.
  - FULL → EMPTY on drain without accept.
  - FULL → FULL on drain with accept, or no drain.
- `rsp_data` and `rsp_id` are stable while rsp_valid && !rsp_ready.
- Requesters may drop valid without a handshake. Nothing is latched from inputs unless accepted.
- Fairness: under continuous dual requests, grants strictly alternate. No requester waits more than one accept.

## Timing
- Reset (async assert, sync release): rsp_valid=0, rsp_data=0, rsp_id=0, prio=0, grant counters=0, state EMPTY. req*_ready read 0 during reset.
- Latency: request accepted in cycle T → rsp_valid=1 with result after edge T+1.
- `reqX_ready` depends combinationally on reqX_valid, the other valid, prio, rsp_valid and rsp_ready. No combinational path from req data to rsp outputs.
- Reset asserted mid-transaction: held result discarded, counters cleared. After release the first grant uses prio=0.

## Structure
- Shared package: width constants DATA_W=26, OUT_W=32, LEN_16=1'b0, LEN_26=1'b1, state encoding EMPTY/FULL.
- One sub-module, `ext_datapath`: combinational (data[25:0], len, zext) → 32-bit result, instantiated once after the grant mux. The arbiter owns all sequential logic.

## Test plan
- req0 data=16'hFF0F, len=0, zext=0, rsp_ready=1 → next cycle rsp_data=32'hFFFFFF0F, rsp_id=0, grant_cnt0=1.
- req1 data=26'h2000000, len=1, zext=0 → 32'hFE000000, rsp_id=1. Same data with zext=1 → 32'h02000000. req0 16'h8000 with zext=1 → 32'h00008000. req0 data=26'h3FF0F0F, len=0, zext=0 → upper bits ignored, 32'h00000F0F.
- Both valid continuously for 6 cycles, rsp_ready=1 → rsp_id sequence 0,1,0,1,0,1. grant_cnt0=grant_cnt1=3.
- Backpressure: rsp_ready=0 for 4 cycles after one accept → rsp_data/rsp_id stable, both req_ready=0. Raise rsp_ready → drain and new accept in the same cycle, rsp_valid stays 1.
- Reset asserted while rsp_valid=1 and both requesters valid → outputs immediately 0. After release the first grant goes to req0.
- Counter saturation with CNT_W=2: 5 accepts on req0 → grant_cnt0=3.
